// File: rtl/frame_buf_pkg.sv
// Shared constants and types for the ping-pong frame buffer.
//   DEF_DATA_WIDTH  : default word width
//   DEF_FRAME_DEPTH : default words per frame (power of two, >= 2)
//   bank_t          : bank index (0 or 1)
package frame_buf_pkg;

  localparam int unsigned DEF_DATA_WIDTH  = 32;
  localparam int unsigned DEF_FRAME_DEPTH = 16;

  typedef logic bank_t;

endpackage

// File: rtl/frame_buf_dpram.sv
// Simple dual-port synchronous RAM: one write port, one registered read port.
// Ports:
//   clk, rst_n         : clock, async active-low reset (read register only)
//   we_i/waddr_i/wdata_i : write port
//   re_i/raddr_i       : read request and address
//   rdata_o            : registered read data, holds when re_i is low
module frame_buf_dpram
  import frame_buf_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned DEPTH      = 2 * DEF_FRAME_DEPTH,
  localparam int unsigned AW        = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we_i,
  input  logic [AW-1:0]         waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic                  re_i,
  input  logic [AW-1:0]         raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  // Storage array; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Read register; cleared on reset, holds its value between reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/frame_buf_pp.sv
// Ping-pong (double-buffered) frame buffer: two banks of FRAME_DEPTH words.
// The writer fills one bank while the reader drains the other.
// Optional macro FRAME_BUF_REPEAT_EN: when the reader finishes a frame and the
// other bank is not yet full, the same frame is replayed instead of released.
// Ports:
//   clk, reset        : clock, async active-low reset
//   wr_en_in, data_in : write request and data
//   rd_en_in          : read request
//   data_out          : registered read data (holds when no read)
//   data_valid        : data_out was read in the previous cycle
//   wr_full           : both banks full (combinational from registers)
//   rd_avail          : read bank holds a complete frame (combinational from registers)
//   wr_overflow       : one-cycle pulse, write dropped
//   rd_underflow      : one-cycle pulse, read ignored
module frame_buf_pp
  import frame_buf_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int unsigned FRAME_DEPTH = DEF_FRAME_DEPTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en_in,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  rd_en_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic                  wr_full,
  output logic                  rd_avail,
  output logic                  wr_overflow,
  output logic                  rd_underflow
);

  localparam int unsigned ADDR_WIDTH = $clog2(FRAME_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(FRAME_DEPTH - 1);

  logic [1:0]            full_q, full_d;
  bank_t                 wr_bank_q, wr_bank_d;
  bank_t                 rd_bank_q, rd_bank_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic                  data_valid_q;
  logic                  wr_overflow_q;
  logic                  rd_underflow_q;

  logic wr_acc_c, rd_acc_c;

  // Accept writes into an empty bank and reads from a full bank.
  assign wr_acc_c = wr_en_in & ~full_q[wr_bank_q];
  assign rd_acc_c = rd_en_in &  full_q[rd_bank_q];

  // Pointer, bank and full-flag next state. An accepted write and read always
  // target different banks, so their flag updates never collide.
  always_comb begin
    full_d    = full_q;
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    wr_addr_d = wr_addr_q;
    rd_addr_d = rd_addr_q;

    if (wr_acc_c) begin
      wr_addr_d = wr_addr_q + ADDR_WIDTH'(1);
      if (wr_addr_q == LAST_ADDR) begin
        full_d[wr_bank_q] = 1'b1;
        wr_bank_d         = ~wr_bank_q;
      end
    end

    if (rd_acc_c) begin
      rd_addr_d = rd_addr_q + ADDR_WIDTH'(1);
      if (rd_addr_q == LAST_ADDR) begin
`ifdef FRAME_BUF_REPEAT_EN
        // Release the frame only if the next one is already complete.
        if (full_q[~rd_bank_q]) begin
          full_d[rd_bank_q] = 1'b0;
          rd_bank_d         = ~rd_bank_q;
        end
`else
        full_d[rd_bank_q] = 1'b0;
        rd_bank_d         = ~rd_bank_q;
`endif
      end
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      full_q         <= '0;
      wr_bank_q      <= 1'b0;
      rd_bank_q      <= 1'b0;
      wr_addr_q      <= '0;
      rd_addr_q      <= '0;
      data_valid_q   <= 1'b0;
      wr_overflow_q  <= 1'b0;
      rd_underflow_q <= 1'b0;
    end else begin
      full_q         <= full_d;
      wr_bank_q      <= wr_bank_d;
      rd_bank_q      <= rd_bank_d;
      wr_addr_q      <= wr_addr_d;
      rd_addr_q      <= rd_addr_d;
      data_valid_q   <= rd_acc_c;
      wr_overflow_q  <= wr_en_in & full_q[wr_bank_q];
      rd_underflow_q <= rd_en_in & ~full_q[rd_bank_q];
    end
  end

  frame_buf_dpram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (2 * FRAME_DEPTH)
  ) u_dpram (
    .clk     (clk),
    .rst_n   (reset),
    .we_i    (wr_acc_c),
    .waddr_i ({wr_bank_q, wr_addr_q}),
    .wdata_i (data_in),
    .re_i    (rd_acc_c),
    .raddr_i ({rd_bank_q, rd_addr_q}),
    .rdata_o (data_out)
  );

  assign data_valid   = data_valid_q;
  assign wr_overflow  = wr_overflow_q;
  assign rd_underflow = rd_underflow_q;
  assign wr_full      = full_q[0] & full_q[1];
  assign rd_avail     = full_q[rd_bank_q];

endmodule

// File: doc/frame_buf_pp.md
FRAME_BUF_PP -- requirements
Module: frame_buf_pp

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, pixel/word width in bits.
REQ-002 SHALL have parameter FRAME_DEPTH, default 16, words per frame (power of two, >= 2).
REQ-003 SHALL derive local ADDR_WIDTH = clog2(FRAME_DEPTH).
REQ-004 SHALL have port clk  input  1  single clock, all logic rising-edge.
REQ-005 SHALL have port reset  input  1  asynchronous active-low reset.
REQ-006 SHALL have port wr_en_in  input  1  write request, active-high.
REQ-007 SHALL have port data_in  input  DATA_WIDTH  write data.
REQ-008 SHALL have port rd_en_in  input  1  read request, active-high.
REQ-009 SHALL have port data_out  output  DATA_WIDTH  registered read data.
REQ-010 SHALL have port data_valid  output  1  data_out holds a word read the previous cycle.
REQ-011 SHALL have port wr_full  output  1  both banks full; a write now is dropped.
REQ-012 SHALL have port rd_avail  output  1  current read bank holds a complete frame.
REQ-013 SHALL have port wr_overflow  output  1  one-cycle pulse: write dropped.
REQ-014 SHALL have port rd_underflow  output  1  one-cycle pulse: read ignored.

Function
REQ-015 SHALL hold two banks (0,1) of FRAME_DEPTH words, each with a full flag.
REQ-016 SHALL accept a write when wr_en_in=1 and full[wr_bank]=0, storing data_in at {wr_bank, wr_addr}, then wr_addr+1.
REQ-017 SHALL, on a write at wr_addr=FRAME_DEPTH-1, set full[wr_bank], toggle wr_bank, wrap wr_addr to 0.
REQ-018 SHALL accept a read when rd_en_in=1 and full[rd_bank]=1, driving data_out=mem[{rd_bank, rd_addr}] and data_valid=1 exactly one cycle later, then rd_addr+1.
REQ-019 SHALL, on a read at rd_addr=FRAME_DEPTH-1, apply end-of-frame per REQ-030/031 and wrap rd_addr to 0.
REQ-020 SHALL drive data_valid=0 in any cycle following no accepted read; data_out SHALL hold its last value.
REQ-021 SHALL pulse wr_overflow for one cycle when wr_en_in=1 and full[wr_bank]=1; no pointer or memory change.
REQ-022 SHALL pulse rd_underflow for one cycle when rd_en_in=1 and full[rd_bank]=0; no pointer change, data_valid=0 next cycle.
REQ-023 SHALL allow an accepted write and an accepted read in the same cycle; they always target different banks, and set/clear of different full flags both take effect.
REQ-024 SHALL drive wr_full = full[0] & full[1] and rd_avail = full[rd_bank], combinational from registers.

Reset
REQ-025 SHALL, on reset=0, immediately clear full[1:0], wr_bank, rd_bank, wr_addr, rd_addr, data_out, data_valid, wr_overflow, rd_underflow.
REQ-026 SHALL discard partially written and partially read frames on reset mid-operation; memory contents need not be cleared.
REQ-027 SHALL resume normal operation on the first rising clk edge after reset deasserts.

Configuration
REQ-028 SHALL recognise macro FRAME_BUF_REPEAT_EN.
REQ-029 SHALL select end-of-frame behaviour by FRAME_BUF_REPEAT_EN.
REQ-030 Without FRAME_BUF_REPEAT_EN: end of read frame SHALL clear full[rd_bank] and toggle rd_bank.
REQ-031 With FRAME_BUF_REPEAT_EN: end of read frame SHALL clear full[rd_bank] and toggle rd_bank only if full[~rd_bank]=1; otherwise keep full[rd_bank] set and replay the same frame from address 0.

Structure
REQ-032 SHALL take default DATA_WIDTH/FRAME_DEPTH constants and a bank-index typedef from shared package frame_buf_pkg.
REQ-033 SHALL instantiate sub-module frame_buf_dpram: simple dual-port synchronous RAM, 2*FRAME_DEPTH words, one write port, one registered read port.

Verification (DATA_WIDTH=32, FRAME_DEPTH=4)
REQ-034 Write 1,2,3,4 then read 4 cycles -> rd_avail=1 after 4th write; data_out 1,2,3,4 with data_valid one cycle after each read.
REQ-035 Write 8 words (1..8) with no reads, then a 9th -> wr_full=1, wr_overflow pulses once, reads return 1..8 in order.
REQ-036 Read after reset with no writes -> rd_underflow pulses, data_valid=0, data_out=0.
REQ-037 Simultaneous write of frame 5..8 while reading frame 1..4 -> no overflow/underflow, next frame reads 5..8.
REQ-038 Reset asserted after 2 of 4 writes -> full=0, rd_avail=0; subsequent 4 writes 9..12 read back as 9..12.
REQ-039 With FRAME_BUF_REPEAT_EN, one frame 1..4, read 8 cycles -> data_out 1,2,3,4,1,2,3,4, no underflow; without it -> 1,2,3,4 then 4 rd_underflow pulses.
